// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and FIFO entry layout for the instruction fetch unit.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Hazard-unit controls, instruction-memory handshake and IF/ID outputs of the fetch unit.
interface fetch_unit_if;

    logic        pcStop;
    logic        ifIdWrite;
    logic        ifIdFlush;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemValid;
    logic [31:0] imemData;
    logic [31:0] instrOut;
    logic [31:0] pcPlus4Out;
    logic        instrValid;

    modport master (
        input  pcStop, ifIdWrite, ifIdFlush, branchTaken, branchTarget,
        input  imemReady, imemValid, imemData,
        output imemReq, imemAddr, instrOut, pcPlus4Out, instrValid
    );

    modport slave (
        output pcStop, ifIdWrite, ifIdFlush, branchTaken, branchTarget,
        output imemReady, imemValid, imemData,
        input  imemReq, imemAddr, instrOut, pcPlus4Out, instrValid
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry buffer of {instruction, pc+4} between the memory response and the IF/ID register.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output fetch_entry_t head_data,
    output logic [1:0]   count
);

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    fetch_entry_t mem_q [FIFO_DEPTH];
    fetch_entry_t mem_d [FIFO_DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Underflow and overflow are blocked here as well, so a misbehaving caller cannot corrupt the pointers.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != FULL) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, 2-entry response buffer, IF/ID register.
//   state | meaning
//   FETCH | no request in flight; may issue one when buffer space allows
//   WAIT  | request accepted, response will be buffered
//   DRAIN | request in flight was redirected away; its response is dropped
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic         valid_q, valid_d;

    logic         fifo_push, fifo_pop, fifo_clear;
    logic [1:0]   fifo_count;
    fetch_entry_t push_entry, head_entry;

    logic         outstanding;
    logic         slot_free;
    logic         imem_req;
    logic         accept;

    assign outstanding = (state_q != FETCH);
    assign slot_free   = ({1'b0, fifo_count} + {2'b00, outstanding}) < 3'(FIFO_DEPTH);
    assign imem_req    = (state_q == FETCH) && !bus.pcStop && !bus.branchTaken && slot_free;
    assign accept      = imem_req && bus.imemReady;

    assign push_entry.instr    = bus.imemData;
    assign push_entry.pc_plus4 = req_pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        fifo_push  = 1'b0;
        fifo_clear = bus.branchTaken;
        case (state_q)
            FETCH: begin
                if (accept) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // A response landing with a redirect completes the request but is not kept.
                if (bus.imemValid) begin
                    fifo_push = !bus.branchTaken;
                    state_d   = FETCH;
                end else if (bus.branchTaken) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imemValid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (bus.branchTaken) begin
            pc_d = align_word(bus.branchTarget);
        end
    end

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        fifo_pop   = 1'b0;
        if (bus.branchTaken || bus.ifIdFlush) begin
            instr_d    = NOP;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (bus.ifIdWrite) begin
            if (fifo_count != 2'd0) begin
                instr_d    = head_entry.instr;
                pc_plus4_d = head_entry.pc_plus4;
                valid_d    = 1'b1;
                fifo_pop   = 1'b1;
            end else begin
                instr_d    = NOP;
                pc_plus4_d = '0;
                valid_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            instr_q    <= NOP;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    fetch_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (push_entry),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign bus.imemReq    = imem_req;
    assign bus.imemAddr   = pc_q;
    assign bus.instrOut   = instr_q;
    assign bus.pcPlus4Out = pc_plus4_q;
    assign bus.instrValid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario and randomized checks of fetch_unit against a queue-based model of the fetch stream.
module tb_fetch_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_unit_if bus();

    fetch_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [63:0] pq[$];
    logic [63:0] outs[$];
    logic [31:0] exp_pc, exp_instr, exp_pcp4;
    logic        exp_valid;

    bit          mem_busy, mem_wrong, stale_valid;
    int          mem_wait, min_lat, max_lat;
    logic [31:0] mem_addr;

    logic        last_req, last_acc, last_valid;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd12) return ((a >> 2) + 32'd1) * 32'h11;
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic model_clear();
        pq.delete();
        exp_pc    = 32'h0;
        exp_instr = 32'h0;
        exp_pcp4  = 32'h0;
        exp_valid = 1'b0;
        mem_busy  = 0;
        mem_wrong = 0;
        mem_wait  = 0;
    endtask

    // One clock cycle: act as memory, check the request side, advance the model, check IF/ID.
    task automatic tick();
        logic        resp, exp_req, wr;
        logic [63:0] head;
        if (mem_busy && mem_wait == 0) begin
            bus.imemValid = 1'b1;
            bus.imemData  = mem_word(mem_addr);
        end else if (stale_valid) begin
            bus.imemValid = 1'b1;
            bus.imemData  = 32'hDEAD;
        end else begin
            bus.imemValid = 1'b0;
            bus.imemData  = 32'h0;
        end
        #1;
        resp      = mem_busy && (mem_wait == 0);
        exp_req   = !bus.pcStop && !bus.branchTaken && !mem_busy && (pq.size() < 2);
        last_req  = bus.imemReq;
        last_acc  = bus.imemReq && bus.imemReady;
        last_addr = bus.imemAddr;
        wr        = bus.ifIdWrite && !bus.branchTaken && !bus.ifIdFlush;
        n_checks++;
        if (bus.imemReq !== exp_req) begin
            n_fail++;
            $display("FAIL imem_req t=%0t got %b want %b", $time, bus.imemReq, exp_req);
        end
        if (last_acc) begin
            n_checks++;
            if (bus.imemAddr !== exp_pc) begin
                n_fail++;
                $display("FAIL imem_addr t=%0t got %h want %h", $time, bus.imemAddr, exp_pc);
            end
        end
        if (bus.branchTaken || bus.ifIdFlush) begin
            exp_valid = 1'b0;
            exp_instr = 32'h0;
        end else if (bus.ifIdWrite) begin
            if (pq.size() > 0) begin
                head      = pq.pop_front();
                exp_instr = head[63:32];
                exp_pcp4  = head[31:0];
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
                exp_instr = 32'h0;
            end
        end
        if (resp && !mem_wrong && !bus.branchTaken)
            pq.push_back({mem_word(mem_addr), mem_addr + 32'd4});
        if (resp) begin
            mem_busy  = 0;
            mem_wrong = 0;
        end else if (mem_busy) begin
            mem_wait--;
        end
        if (bus.branchTaken) begin
            pq.delete();
            exp_pc = bus.branchTarget & ~32'h3;
            if (mem_busy) mem_wrong = 1;
        end
        if (last_acc) begin
            mem_busy = 1;
            mem_addr = exp_pc;
            mem_wait = $urandom_range(max_lat, min_lat);
            exp_pc   = exp_pc + 32'd4;
        end
        @(posedge clock);
        @(negedge clock);
        bus.branchTaken = 1'b0;
        bus.ifIdFlush   = 1'b0;
        stale_valid     = 0;
        last_valid      = bus.instrValid;
        n_checks++;
        if (bus.instrValid !== exp_valid) begin
            n_fail++;
            $display("FAIL instr_valid t=%0t got %b want %b", $time, bus.instrValid, exp_valid);
        end
        n_checks++;
        if (bus.instrOut !== exp_instr) begin
            n_fail++;
            $display("FAIL instr_out t=%0t got %h want %h", $time, bus.instrOut, exp_instr);
        end
        if (exp_valid) begin
            n_checks++;
            if (bus.pcPlus4Out !== exp_pcp4) begin
                n_fail++;
                $display("FAIL pc_plus4 t=%0t got %h want %h", $time, bus.pcPlus4Out, exp_pcp4);
            end
        end
        if (wr && bus.instrValid) outs.push_back({bus.instrOut, bus.pcPlus4Out});
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        bus.imemValid = 1'b0;
        #1;
        model_clear();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (bus.instrValid !== 1'b0 || bus.instrOut !== 32'h0 || bus.pcPlus4Out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b i=%h p=%h want 0", bus.instrValid, bus.instrOut, bus.pcPlus4Out);
        end
        n_checks++;
        if (bus.imemAddr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr got %h want 00000000", bus.imemAddr);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        tick();
        n_checks++;
        if (!(last_acc && last_addr === 32'h0)) begin
            n_fail++;
            $display("FAIL first_request got acc=%b addr=%h want 1/00000000", last_acc, last_addr);
        end
    endtask

    task automatic test_stream();
        logic [63:0] want;
        outs.delete();
        for (int k = 0; k < 20 && outs.size() < 3; k++) tick();
        n_checks++;
        if (outs.size() < 3) begin
            n_fail++;
            $display("FAIL stream_timeout got %0d outputs want 3", outs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                want = {32'h11 * (i + 1), 32'(4 * (i + 1))};
                n_checks++;
                if (outs[i] !== want) begin
                    n_fail++;
                    $display("FAIL stream_%0d got %h want %h", i, outs[i], want);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold_instr;
        logic        hold_valid;
        apply_reset();
        outs.delete();
        repeat (3) tick();
        hold_instr    = bus.instrOut;
        hold_valid    = bus.instrValid;
        bus.ifIdWrite = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (bus.instrOut !== hold_instr || bus.instrValid !== hold_valid) begin
                n_fail++;
                $display("FAIL bp_hold got %b/%h want %b/%h", bus.instrValid, bus.instrOut, hold_valid, hold_instr);
            end
        end
        n_checks++;
        if (last_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_req_drop got %b want 0", last_req);
        end
        bus.ifIdWrite = 1'b1;
        for (int k = 0; k < 30 && outs.size() < 5; k++) tick();
        n_checks++;
        if (outs.size() < 5) begin
            n_fail++;
            $display("FAIL bp_timeout got %0d outputs want 5", outs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (outs[i][31:0] !== 32'(4 * (i + 1))) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d got %h want %h", i, outs[i][31:0], 4 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_pcstop();
        logic [31:0] a;
        bit          got, found;
        min_lat = 2;
        max_lat = 2;
        outs.delete();
        got = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) begin got = 1; break; end
        end
        a = last_addr;
        bus.pcStop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (last_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_req got %b want 0", last_req);
            end
        end
        bus.pcStop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) break;
        end
        n_checks++;
        if (!got || !last_acc || last_addr !== a + 32'd4) begin
            n_fail++;
            $display("FAIL stall_resume got acc=%b addr=%h want 1/%h", last_acc, last_addr, a + 32'd4);
        end
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            foreach (outs[i]) if (outs[i][31:0] === a + 32'd4) found = 1;
            if (!found) tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL stall_pushed got none want pc+4=%h", a + 32'd4);
        end
    endtask

    task automatic test_branch_wait();
        logic [31:0] a;
        bit          seen;
        min_lat = 2;
        max_lat = 2;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) break;
        end
        a = last_addr;
        outs.delete();
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'h100;
        tick();
        n_checks++;
        if (last_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL br_bubble got %b want 0", last_valid);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) break;
        end
        n_checks++;
        if (!last_acc || last_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL br_target got acc=%b addr=%h want 1/00000100", last_acc, last_addr);
        end
        seen = 0;
        foreach (outs[i]) if (outs[i][31:0] === a + 32'd4) seen = 1;
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL br_discard got stale pc+4=%h want none", a + 32'd4);
        end
    endtask

    task automatic test_misaligned();
        min_lat = 0;
        max_lat = 0;
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'h203;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) break;
        end
        n_checks++;
        if (!last_acc || last_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL misaligned got acc=%b addr=%h want 1/00000200", last_acc, last_addr);
        end
    endtask

    task automatic test_midfetch_reset();
        min_lat = 2;
        max_lat = 2;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) break;
        end
        reset         = 1'b0;
        bus.imemValid = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (bus.instrValid !== 1'b0 || bus.instrOut !== 32'h0 || bus.pcPlus4Out !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got v=%b i=%h p=%h want 0", bus.instrValid, bus.instrOut, bus.pcPlus4Out);
        end
        n_checks++;
        if (bus.imemAddr !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_addr got %h want 00000000", bus.imemAddr);
        end
        repeat (2) @(negedge clock);
        reset       = 1'b1;
        min_lat     = 0;
        max_lat     = 0;
        stale_valid = 1;
        outs.delete();
        tick();
        n_checks++;
        if (!last_acc || last_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_first got acc=%b addr=%h want 1/00000000", last_acc, last_addr);
        end
        for (int k = 0; k < 10 && outs.size() < 1; k++) tick();
        n_checks++;
        if (outs.size() < 1 || outs[0][63:32] !== 32'h11) begin
            n_fail++;
            $display("FAIL mid_reset_stale got n=%0d first=%h want 00000011", outs.size(),
                     (outs.size() > 0) ? outs[0][63:32] : 32'h0);
        end
    endtask

    task automatic test_random();
        min_lat = 0;
        max_lat = 3;
        for (int k = 0; k < 400; k++) begin
            bus.ifIdWrite    = ($urandom_range(99) < 80);
            bus.pcStop       = ($urandom_range(99) < 15);
            bus.ifIdFlush    = ($urandom_range(99) < 5);
            bus.branchTaken  = ($urandom_range(99) < 6);
            bus.branchTarget = $urandom;
            bus.imemReady    = ($urandom_range(99) < 70);
            tick();
        end
        bus.ifIdWrite = 1'b1;
        bus.pcStop    = 1'b0;
        bus.imemReady = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bus.pcStop       = 1'b0;
        bus.ifIdWrite    = 1'b1;
        bus.ifIdFlush    = 1'b0;
        bus.branchTaken  = 1'b0;
        bus.branchTarget = 32'h0;
        bus.imemReady    = 1'b1;
        bus.imemValid    = 1'b0;
        bus.imemData     = 32'h0;
        stale_valid      = 0;
        min_lat          = 0;
        max_lat          = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_pcstop();
        test_branch_wait();
        test_misaligned();
        test_midfetch_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, single clock domain for the whole block.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: pcStop  in  1  load-use stall from the hazard unit; no new fetch request is issued while high.
REQ-004 SHALL have ports: ifIdWrite  in  1  IF/ID output register enable from the hazard unit.
REQ-005 SHALL have ports: ifIdFlush  in  1  turns the IF/ID output into a bubble.
REQ-006 SHALL have ports: branchTaken  in  1  one-cycle redirect pulse.
REQ-007 SHALL have ports: branchTarget  in  32  redirect address.
REQ-008 SHALL have ports: imemReq  out  1  instruction memory request valid.
REQ-009 SHALL have ports: imemAddr  out  32  request address, equal to the current PC.
REQ-010 SHALL have ports: imemReady  in  1  memory accepts the request.
REQ-011 SHALL have ports: imemValid  in  1  response valid.
REQ-012 SHALL have ports: imemData  in  32  response instruction word.
REQ-013 SHALL have ports: instrOut  out  32  IF/ID instruction.
REQ-014 SHALL have ports: pcPlus4Out  out  32  IF/ID PC+4 of the instruction in instrOut.
REQ-015 SHALL have ports: instrValid  out  1  IF/ID holds a real instruction.

Function
REQ-016 SHALL implement a three-state FSM with states FETCH, WAIT and DRAIN, and SHALL allow at most one memory request outstanding.
REQ-017 In FETCH, imemReq SHALL be 1 only when pcStop=0, branchTaken=0, and (FIFO count + outstanding) < 2.
REQ-018 A request handshake (imemReq & imemReady) SHALL capture reqPc <= pc, set pc <= pc+4 (wrapping modulo 2^32), and move the FSM to WAIT.
REQ-019 In WAIT, imemValid SHALL push {imemData, reqPc+4} into the FIFO and move the FSM to FETCH; the next request is issued no earlier than the following cycle.
REQ-020 In FETCH, imemValid SHALL be ignored.
REQ-021 A branchTaken pulse SHALL do all of the following: set pc <= {branchTarget[31:2], 2'b00}; clear the FIFO; force instrOut=0x00000000 and instrValid=0 on the next edge.
REQ-022 On branchTaken, the FSM SHALL go to DRAIN if a request is outstanding or is being accepted in the same cycle, and SHALL stay in (or go to) FETCH otherwise.
REQ-023 In DRAIN, the next imemValid SHALL be discarded (no push) and the FSM SHALL return to FETCH; a second branchTaken while in DRAIN SHALL update pc only.
REQ-024 The IF/ID output register SHALL update with this priority: (1) branchTaken or ifIdFlush produces a bubble (instr 0, valid 0) with no FIFO pop; (2) ifIdWrite=0 holds all outputs with no pop; (3) if the FIFO is non-empty, pop the head into the outputs with valid=1; (4) if the FIFO is empty, produce a bubble.
REQ-025 A FIFO push and pop in the same cycle SHALL both take effect; the FIFO SHALL never overflow, as guaranteed by REQ-017, and SHALL never be popped when empty.
REQ-026 pcStop SHALL NOT cancel an outstanding request; its response is still pushed into the FIFO.

Reset
REQ-027 While reset=0, the block SHALL asynchronously set: pc=0x00000000, FSM=FETCH, FIFO empty, outstanding=0, instrOut=0, pcPlus4Out=0, instrValid=0.
REQ-028 A reset asserted mid-transaction SHALL abandon the in-flight request, and any imemValid arriving after reset release SHALL be ignored per REQ-020.
REQ-029 The first request SHALL be issued in the first cycle after reset release, with imemAddr=0x00000000.

Structure
REQ-030 The shared header Fetch.vh SHALL hold: RESET_PC=32'h0, NOP=32'h0, FIFO_DEPTH=2, and the state encodings FETCH=2'd0, WAIT=2'd1, DRAIN=2'd2.
REQ-031 The 2-entry, 64-bit-wide FIFO SHALL be a separate sub-module named fetch_fifo, with push, pop, count, and a synchronous clear input.
REQ-032 All other logic SHALL reside in fetch_unit, and the output register SHALL be built from flops (not latches).

Verification
REQ-033 Scenario, reset then stream: imemReady=1, and imemValid is returned one cycle after each accept with data 0x11,0x22,0x33. Required: instrOut carries 0x11/4, 0x22/8, 0x33/12 (instruction/pcPlus4Out) on consecutive valid outputs.
REQ-034 Scenario, backpressure: ifIdWrite=0 for 4 cycles. Required: outputs hold, the FIFO fills to 2, imemReq drops to 0, and no instruction is lost or duplicated after release.
REQ-035 Scenario, pcStop: hold pcStop=1 for 3 cycles while a request is outstanding. Required: that response is pushed, no new imemReq occurs during the stall, and fetching resumes with the next sequential address.
REQ-036 Scenario, branch while in WAIT: branchTaken with target 0x100. Required: the late response is discarded, the next imemAddr is 0x100, and instrValid=0 for at least one cycle.
REQ-037 Scenario, misaligned target: branchTarget=0x203. Required: the next imemAddr is 0x200.
REQ-038 Scenario, mid-fetch reset: drop reset while in WAIT, then raise it. Required: outputs are 0, imemAddr=0x00000000, and a stale imemValid carrying 0xDEAD is not pushed.
